// File: rtl/wb_pkg.sv
// Shared write-back definitions: default widths, source encodings and the
// buffered entry layout used by the write-back select stage.
package wb_pkg;

   localparam int WB_XLEN = 32;
   localparam int WB_REGW = 5;
   localparam int WB_NSRC = 4;

   // Result source encodings presented on in_sel
   typedef enum logic [1:0] {
      WB_SRC_PC  = 2'd0,
      WB_SRC_ALU = 2'd1,
      WB_SRC_MEM = 2'd2,
      WB_SRC_IMM = 2'd3
   } wb_src_e;

   // One write-back entry as seen by the register file
   typedef struct packed {
      logic               valid;
      logic               we;
      logic [WB_REGW-1:0] rd;
      logic [WB_XLEN-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_select_stage_if.sv
// Handshake/bus bundle for the write-back select stage.
// Optional macro WB_BYPASS_EN adds the decode-stage forwarding signals.
interface wb_select_stage_if import wb_pkg::*; #(
   parameter int XLEN = WB_XLEN,
   parameter int NSRC = WB_NSRC,
   parameter int REGW = WB_REGW
) ();
   localparam int SELW = $clog2(NSRC);

   logic                 in_valid;
   logic                 in_ready;
   logic [SELW-1:0]      in_sel;
   logic [NSRC*XLEN-1:0] in_src;
   logic [REGW-1:0]      in_rd;
   logic                 in_we;
   logic                 out_valid;
   logic                 out_ready;
   logic [XLEN-1:0]      out_data;
   logic [REGW-1:0]      out_rd;
   logic                 out_we;
`ifdef WB_BYPASS_EN
   logic [REGW-1:0]      rs1_addr;
   logic [REGW-1:0]      rs2_addr;
   logic                 fwd1_hit;
   logic [XLEN-1:0]      fwd1_data;
   logic                 fwd2_hit;
   logic [XLEN-1:0]      fwd2_data;

   modport slave (
      input  in_valid, in_sel, in_src, in_rd, in_we, out_ready, rs1_addr, rs2_addr,
      output in_ready, out_valid, out_data, out_rd, out_we,
             fwd1_hit, fwd1_data, fwd2_hit, fwd2_data
   );
   modport master (
      output in_valid, in_sel, in_src, in_rd, in_we, out_ready, rs1_addr, rs2_addr,
      input  in_ready, out_valid, out_data, out_rd, out_we,
             fwd1_hit, fwd1_data, fwd2_hit, fwd2_data
   );
`else
   modport slave (
      input  in_valid, in_sel, in_src, in_rd, in_we, out_ready,
      output in_ready, out_valid, out_data, out_rd, out_we
   );
   modport master (
      output in_valid, in_sel, in_src, in_rd, in_we, out_ready,
      input  in_ready, out_valid, out_data, out_rd, out_we
   );
`endif
endinterface

// File: rtl/wb_skid_buffer.sv
// Two-entry skid buffer (MAIN drives the output, SKID absorbs one overflow).
// in_ready depends only on registered state, so there is no combinational
// path from out_ready back to the producer.
module wb_skid_buffer import wb_pkg::*; #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         skid_valid,
   output logic [W-1:0] skid_data
);
   logic         main_valid_q, main_valid_d;
   logic [W-1:0] main_data_q, main_data_d;
   logic         skid_valid_q, skid_valid_d;
   logic [W-1:0] skid_data_q, skid_data_d;
   logic         accept;
   logic         xfer;

   // Next-state: flush wins, then refill MAIN (SKID first, keeping FIFO order), else park input in SKID
   always_comb begin
      accept       = in_valid & ~skid_valid_q;
      xfer         = main_valid_q & out_ready;
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!main_valid_q || xfer) begin
         if (skid_valid_q) begin
            // SKID full means in_ready was low, so nothing new can arrive this cycle
            main_valid_d = 1'b1;
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
         end else begin
            main_valid_d = accept;
            if (accept) main_data_d = in_data;
         end
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_data_d  = in_data;
      end
   end

   // State registers; payloads keep their last value when invalid so out_* hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         main_data_q  <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
      end
   end

   assign in_ready   = ~skid_valid_q;
   assign out_valid  = main_valid_q;
   assign out_data   = main_data_q;
   assign skid_valid = skid_valid_q;
   assign skid_data  = skid_data_q;

endmodule

// File: rtl/wb_select_stage.sv
// Registered write-back stage: selects a result source, qualifies the write
// enable and delivers it to the register file through a 2-entry skid buffer.
// Optional macro WB_BYPASS_EN adds rs1/rs2 forwarding from buffered entries.
module wb_select_stage import wb_pkg::*; #(
   parameter int XLEN = WB_XLEN,
   parameter int NSRC = WB_NSRC,
   parameter int REGW = WB_REGW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   wb_select_stage_if.slave  bus
);
   typedef struct packed {
      logic            we;
      logic [REGW-1:0] rd;
      logic [XLEN-1:0] data;
   } payload_t;

   localparam int PW = $bits(payload_t);

   logic [XLEN-1:0] src_arr [NSRC];
   logic            sel_ok;
   logic [XLEN-1:0] sel_data;
   payload_t        in_pl;
   payload_t        main_pl;
   payload_t        skid_pl;
   logic            main_valid;
   logic            skid_valid;

   for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
      assign src_arr[gi] = bus.in_src[gi*XLEN +: XLEN];
   end

   // Source mux; an out-of-range select yields zero data and suppresses the write
   always_comb begin
      sel_ok   = 1'b0;
      sel_data = '0;
      for (int k = 0; k < NSRC; k++) begin
         if (int'(bus.in_sel) == k) begin
            sel_ok   = 1'b1;
            sel_data = src_arr[k];
         end
      end
   end

   // x0 is never written, but its data is still carried for visibility
   always_comb begin
      in_pl.we   = bus.in_we & sel_ok & (bus.in_rd != '0);
      in_pl.rd   = bus.in_rd;
      in_pl.data = sel_data;
   end

   wb_skid_buffer #(.W(PW)) u_skid (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (bus.in_valid),
      .in_ready   (bus.in_ready),
      .in_data    (in_pl),
      .out_valid  (main_valid),
      .out_ready  (bus.out_ready),
      .out_data   (main_pl),
      .skid_valid (skid_valid),
      .skid_data  (skid_pl)
   );

   assign bus.out_valid = main_valid;
   assign bus.out_data  = main_pl.data;
   assign bus.out_rd    = main_pl.rd;
   assign bus.out_we    = main_pl.we;

`ifdef WB_BYPASS_EN
   logic [REGW-1:0] rs_addr [2];

   assign rs_addr[0] = bus.rs1_addr;
   assign rs_addr[1] = bus.rs2_addr;

   for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      logic            hit;
      logic [XLEN-1:0] data;
      // SKID holds the younger entry, so it takes priority over MAIN
      always_comb begin
         hit  = 1'b0;
         data = '0;
         if (rs_addr[gi] != '0) begin
            if (skid_valid && skid_pl.we && skid_pl.rd == rs_addr[gi]) begin
               hit  = 1'b1;
               data = skid_pl.data;
            end else if (main_valid && main_pl.we && main_pl.rd == rs_addr[gi]) begin
               hit  = 1'b1;
               data = main_pl.data;
            end
         end
      end
   end

   assign bus.fwd1_hit  = g_fwd[0].hit;
   assign bus.fwd1_data = g_fwd[0].data;
   assign bus.fwd2_hit  = g_fwd[1].hit;
   assign bus.fwd2_data = g_fwd[1].data;
`else
   logic unused_skid;
   assign unused_skid = ^{skid_valid, skid_pl};
`endif

endmodule
